// File: rtl/uart_pkg.sv
// Shared UART receive-side definitions: capture FSM encoding, error-flag bit
// positions and the default receive FIFO depth.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACK  = 2'd1,
        WAIT = 2'd2
    } cap_state_t;

    localparam int ERR_PERR = 0;
    localparam int ERR_FERR = 1;
    localparam int ERR_OVF  = 2;
    localparam int ERR_W    = 3;

    localparam int RX_DEPTH = 16;

endpackage

// File: rtl/rx_buffer_mem.sv
// Receive FIFO storage: DEPTH x W register array, one synchronous write port
// and one asynchronous read port. Storage is intentionally not reset.
module rx_buffer_mem #(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int W     = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/rx_buffer.sv
// Receive buffer between the UART receive engine and the processor side.
// Define RX_BUFFER_ERR_EN to store the per-character error flags alongside the data.
//
//  state | meaning
//  IDLE  | waiting for rxrdy; capture (or drop) happens on the leaving edge
//  ACK   | clr asserted to the engine for this one cycle
//  WAIT  | holding until the engine releases rxrdy
module rx_buffer
    import uart_pkg::*;
#(
    parameter int DEPTH = RX_DEPTH,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rxrdy,
    input  logic [7:0]    rx_data,
    input  logic          ferr,
    input  logic          perr,
    input  logic          ovf,
    output logic          clr,
    input  logic          rd,
    output logic [7:0]    rd_data,
    output logic [2:0]    rd_err,
    output logic          empty,
    output logic          full,
    output logic [AW:0]   count,
    output logic          drop,
    input  logic          drop_clr
);

`ifdef RX_BUFFER_ERR_EN
    localparam int W = 8 + ERR_W;
`else
    localparam int W = 8;
`endif

    cap_state_t    state;
    cap_state_t    state_next;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [W-1:0]  wdata;
    logic [W-1:0]  rdata;
    logic          capture;
    logic          do_rd;
    logic          wr_ok;
    logic          drop_set;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (rxrdy) state_next = ACK;
            ACK:     state_next = WAIT;
            WAIT:    if (!rxrdy) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            clr   <= 1'b0;
        end else begin
            state <= state_next;
            clr   <= (state_next == ACK);
        end
    end

    assign capture  = (state == IDLE) && rxrdy;
    assign do_rd    = rd && !empty;
    // A read on the same edge frees the slot, so a full FIFO can still accept.
    assign wr_ok    = capture && (!full || do_rd);
    assign drop_set = capture && full && !do_rd;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_ok, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)           drop <= 1'b0;
        else if (drop_set) drop <= 1'b1;
        else if (drop_clr) drop <= 1'b0;
    end

    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);

`ifdef RX_BUFFER_ERR_EN
    logic [ERR_W-1:0] err_in;

    always_comb begin
        err_in           = '0;
        err_in[ERR_PERR] = perr;
        err_in[ERR_FERR] = ferr;
        err_in[ERR_OVF]  = ovf;
    end

    assign wdata  = {err_in, rx_data};
    assign rd_err = empty ? 3'b000 : rdata[8 +: ERR_W];
`else
    logic unused_flags;

    assign unused_flags = ^{ferr, perr, ovf};
    assign wdata        = rx_data;
    assign rd_err       = 3'b000;
`endif

    assign rd_data = empty ? 8'h00 : rdata[7:0];

    rx_buffer_mem #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .W     (W)
    ) u_mem (
        .clk   (clk),
        .we    (wr_ok),
        .waddr (wr_ptr),
        .wdata (wdata),
        .raddr (rd_ptr),
        .rdata (rdata)
    );

endmodule

// File: tb/tb_rx_buffer.sv
// Self-checking bench for rx_buffer: random characters against a queue-based
// model of the receive FIFO and its sticky drop flag.
module tb_rx_buffer;
    import uart_pkg::*;

    localparam int DEPTH = RX_DEPTH;
    localparam int AW    = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          rxrdy;
    logic [7:0]    rx_data;
    logic          ferr;
    logic          perr;
    logic          ovf;
    logic          clr;
    logic          rd;
    logic [7:0]    rd_data;
    logic [2:0]    rd_err;
    logic          empty;
    logic          full;
    logic [AW:0]   count;
    logic          drop;
    logic          drop_clr;

    int n_checks = 0;
    int n_fail   = 0;

    logic [10:0] q[$];
    logic        drop_m;

    always #5 clk = ~clk;

    rx_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk      (clk),
        .rst      (rst),
        .rxrdy    (rxrdy),
        .rx_data  (rx_data),
        .ferr     (ferr),
        .perr     (perr),
        .ovf      (ovf),
        .clr      (clr),
        .rd       (rd),
        .rd_data  (rd_data),
        .rd_err   (rd_err),
        .empty    (empty),
        .full     (full),
        .count    (count),
        .drop     (drop),
        .drop_clr (drop_clr)
    );

    function automatic logic [7:0] head_data();
        return (q.size() > 0) ? q[0][7:0] : 8'h00;
    endfunction

    function automatic logic [2:0] head_err();
`ifdef RX_BUFFER_ERR_EN
        return (q.size() > 0) ? q[0][10:8] : 3'b000;
`else
        return 3'b000;
`endif
    endfunction

    // One engine handshake: rxrdy until clr is seen, optional rd/drop_clr in the capture cycle.
    task automatic send_char(input logic [7:0] d, input logic [2:0] f,
                             input logic with_rd, input logic with_clr);
        @(negedge clk);
        rxrdy = 1'b1; rx_data = d; {ovf, ferr, perr} = f;
        rd = with_rd; drop_clr = with_clr;
        if (with_rd && q.size() > 0) void'(q.pop_front());
        if (q.size() < DEPTH) begin
            q.push_back({f, d});
            if (with_clr) drop_m = 1'b0;
        end else begin
            drop_m = 1'b1;
        end
        @(negedge clk);
        rd = 1'b0; drop_clr = 1'b0; rxrdy = 1'b0;
        n_checks++;
        if (clr !== 1'b1) begin
            n_fail++; $display("FAIL clr_pulse: got %b expected 1", clr);
        end
        @(negedge clk);
        n_checks++;
        if (clr !== 1'b0) begin
            n_fail++; $display("FAIL clr_width: got %b expected 0", clr);
        end
        @(negedge clk);
    endtask

    task automatic read_one(output logic [7:0] d, output logic [2:0] e);
        @(negedge clk);
        d = rd_data; e = rd_err;
        rd = 1'b1;
        if (q.size() > 0) void'(q.pop_front());
        @(negedge clk);
        rd = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; rxrdy = 1'b0; rx_data = 8'h00; {ovf, ferr, perr} = 3'b000;
        rd = 1'b0; drop_clr = 1'b0;
        q.delete(); drop_m = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_checks++; if (clr !== 1'b0)     begin n_fail++; $display("FAIL reset_clr: got %b expected 0", clr); end
        n_checks++; if (empty !== 1'b1)   begin n_fail++; $display("FAIL reset_empty: got %b expected 1", empty); end
        n_checks++; if (full !== 1'b0)    begin n_fail++; $display("FAIL reset_full: got %b expected 0", full); end
        n_checks++; if (count !== '0)     begin n_fail++; $display("FAIL reset_count: got %0d expected 0", count); end
        n_checks++; if (drop !== 1'b0)    begin n_fail++; $display("FAIL reset_drop: got %b expected 0", drop); end
        n_checks++; if (rd_data !== 8'h0) begin n_fail++; $display("FAIL reset_rd_data: got %h expected 00", rd_data); end
        n_checks++; if (rd_err !== 3'b0)  begin n_fail++; $display("FAIL reset_rd_err: got %b expected 000", rd_err); end
    endtask

    task automatic test_single_char();
        logic [7:0] d;
        logic [2:0] e;
        logic [2:0] exp_e;
        send_char(8'h41, 3'b001, 1'b0, 1'b0);
`ifdef RX_BUFFER_ERR_EN
        exp_e = 3'b001;
`else
        exp_e = 3'b000;
`endif
        n_checks++; if (empty !== 1'b0)    begin n_fail++; $display("FAIL single_empty: got %b expected 0", empty); end
        n_checks++; if (count !== 5'd1)    begin n_fail++; $display("FAIL single_count: got %0d expected 1", count); end
        n_checks++; if (rd_data !== 8'h41) begin n_fail++; $display("FAIL single_rd_data: got %h expected 41", rd_data); end
        n_checks++; if (rd_err !== exp_e)  begin n_fail++; $display("FAIL single_rd_err: got %b expected %b", rd_err, exp_e); end
        read_one(d, e);
        n_checks++; if (empty !== 1'b1)    begin n_fail++; $display("FAIL single_empty_after_rd: got %b expected 1", empty); end
        n_checks++; if (rd_data !== 8'h00) begin n_fail++; $display("FAIL single_rd_data_after_rd: got %h expected 00", rd_data); end
    endtask

    task automatic test_held_ready();
        logic [7:0] d, got;
        logic [2:0] f, got_e, exp_e;
        d = 8'($urandom); f = 3'($urandom_range(0, 7));
        @(negedge clk);
        rxrdy = 1'b1; rx_data = d; {ovf, ferr, perr} = f;
        q.push_back({f, d});
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            n_checks++;
            if (count !== 5'd1) begin n_fail++; $display("FAIL held_count[%0d]: got %0d expected 1", i, count); end
            n_checks++;
            if (clr !== (i == 0)) begin n_fail++; $display("FAIL held_clr[%0d]: got %b expected %b", i, clr, (i == 0)); end
        end
        rxrdy = 1'b0;
        repeat (2) @(negedge clk);
        exp_e = head_err();
        read_one(got, got_e);
        n_checks++; if (got !== d)       begin n_fail++; $display("FAIL held_data: got %h expected %h", got, d); end
        n_checks++; if (got_e !== exp_e) begin n_fail++; $display("FAIL held_err: got %b expected %b", got_e, exp_e); end
        n_checks++; if (count !== 5'd0)  begin n_fail++; $display("FAIL held_count_end: got %0d expected 0", count); end
    endtask

    task automatic test_fill_drop();
        logic [7:0] got;
        logic [2:0] got_e, exp_e;
        for (int i = 0; i < 17; i++) begin
            send_char(8'(i), 3'($urandom_range(0, 7)), 1'b0, 1'b0);
            if (i == 15) begin
                n_checks++; if (full !== 1'b1)   begin n_fail++; $display("FAIL fill_full: got %b expected 1", full); end
                n_checks++; if (count !== 5'd16) begin n_fail++; $display("FAIL fill_count: got %0d expected 16", count); end
                n_checks++; if (drop !== 1'b0)   begin n_fail++; $display("FAIL fill_drop_early: got %b expected 0", drop); end
            end
        end
        n_checks++; if (drop !== 1'b1)   begin n_fail++; $display("FAIL fill_drop: got %b expected 1", drop); end
        n_checks++; if (count !== 5'd16) begin n_fail++; $display("FAIL fill_count_after_drop: got %0d expected 16", count); end
        for (int i = 0; i < 16; i++) begin
            exp_e = head_err();
            read_one(got, got_e);
            n_checks++; if (got !== 8'(i))   begin n_fail++; $display("FAIL fill_order[%0d]: got %h expected %h", i, got, 8'(i)); end
            n_checks++; if (got_e !== exp_e) begin n_fail++; $display("FAIL fill_err[%0d]: got %b expected %b", i, got_e, exp_e); end
        end
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL fill_absent_0x10: got empty=%b expected 1", empty); end
    endtask

    task automatic test_full_simul_read();
        logic [7:0] got, exp_d;
        logic [2:0] got_e, exp_e;
        @(negedge clk); drop_clr = 1'b1; drop_m = 1'b0;
        @(negedge clk); drop_clr = 1'b0;
        n_checks++; if (drop !== 1'b0) begin n_fail++; $display("FAIL drop_clr: got %b expected 0", drop); end
        for (int i = 0; i < 16; i++) send_char(8'($urandom), 3'($urandom_range(0, 7)), 1'b0, 1'b0);
        send_char(8'h55, 3'b000, 1'b0, 1'b1);
        n_checks++; if (drop !== drop_m) begin n_fail++; $display("FAIL drop_set_wins: got %b expected %b", drop, drop_m); end
        @(negedge clk); drop_clr = 1'b1; drop_m = 1'b0;
        @(negedge clk); drop_clr = 1'b0;
        send_char(8'hAA, 3'b110, 1'b1, 1'b0);
        n_checks++; if (count !== 5'd16) begin n_fail++; $display("FAIL simul_count: got %0d expected 16", count); end
        n_checks++; if (drop !== 1'b0)   begin n_fail++; $display("FAIL simul_drop: got %b expected 0", drop); end
        n_checks++; if (full !== 1'b1)   begin n_fail++; $display("FAIL simul_full: got %b expected 1", full); end
        for (int i = 0; i < 16; i++) begin
            exp_d = head_data(); exp_e = head_err();
            read_one(got, got_e);
            n_checks++; if (got !== exp_d)   begin n_fail++; $display("FAIL simul_data[%0d]: got %h expected %h", i, got, exp_d); end
            n_checks++; if (got_e !== exp_e) begin n_fail++; $display("FAIL simul_err[%0d]: got %b expected %b", i, got_e, exp_e); end
            if (i == 15) begin
                n_checks++; if (got !== 8'hAA) begin n_fail++; $display("FAIL simul_last: got %h expected aa", got); end
            end
        end
    endtask

    task automatic test_wrap();
        logic [7:0] got, exp_d;
        logic [2:0] got_e, exp_e;
        for (int i = 0; i < 40; i++) begin
            send_char(8'($urandom), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'b0);
            n_checks++;
            if (count !== 5'(q.size()) || count > 5'd2) begin
                n_fail++; $display("FAIL wrap_count[%0d]: got %0d expected %0d", i, count, q.size());
            end
            if (q.size() == 2) begin
                exp_d = head_data(); exp_e = head_err();
                read_one(got, got_e);
                n_checks++; if (got !== exp_d)   begin n_fail++; $display("FAIL wrap_data[%0d]: got %h expected %h", i, got, exp_d); end
                n_checks++; if (got_e !== exp_e) begin n_fail++; $display("FAIL wrap_err[%0d]: got %b expected %b", i, got_e, exp_e); end
            end
        end
        while (q.size() > 0) begin
            exp_d = head_data();
            read_one(got, got_e);
            n_checks++; if (got !== exp_d) begin n_fail++; $display("FAIL wrap_drain: got %h expected %h", got, exp_d); end
        end
        read_one(got, got_e);
        n_checks++; if (count !== 5'd0) begin n_fail++; $display("FAIL wrap_underflow_count: got %0d expected 0", count); end
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL wrap_underflow_empty: got %b expected 1", empty); end
    endtask

    task automatic test_reset_mid_ack();
        logic [7:0] d, got;
        logic [2:0] got_e;
        for (int i = 0; i < 17; i++) send_char(8'($urandom), 3'b000, 1'b0, 1'b0);
        @(negedge clk);
        rxrdy = 1'b1; rx_data = 8'h5A;
        @(negedge clk);
        n_checks++; if (clr !== 1'b1) begin n_fail++; $display("FAIL rst_pre_clr: got %b expected 1", clr); end
        n_checks++; if (drop !== 1'b1) begin n_fail++; $display("FAIL rst_pre_drop: got %b expected 1", drop); end
        #1 rst = 1'b1;
        #1;
        n_checks++; if (clr !== 1'b0)   begin n_fail++; $display("FAIL rst_clr: got %b expected 0", clr); end
        n_checks++; if (count !== 5'd0) begin n_fail++; $display("FAIL rst_count: got %0d expected 0", count); end
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL rst_empty: got %b expected 1", empty); end
        n_checks++; if (drop !== 1'b0)  begin n_fail++; $display("FAIL rst_drop: got %b expected 0", drop); end
        rxrdy = 1'b0;
        q.delete(); drop_m = 1'b0;
        @(negedge clk); rst = 1'b0;
        d = 8'($urandom);
        send_char(d, 3'b000, 1'b0, 1'b0);
        n_checks++; if (count !== 5'd1) begin n_fail++; $display("FAIL rst_resume_count: got %0d expected 1", count); end
        read_one(got, got_e);
        n_checks++; if (got !== d) begin n_fail++; $display("FAIL rst_resume_data: got %h expected %h", got, d); end
    endtask

    initial begin
        test_reset();
        test_single_char();
        test_held_ready();
        test_fill_drop();
        test_full_simul_read();
        test_wrap();
        test_reset_mid_ack();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
